mult_div_ctrl: RTL

//  Sequential signed multiply/divide engine and owner of the HI/LO register pair.

---
 rtl/mult_div_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl
//   Sequential signed multiply/divide engine that owns the HI/LO register
//   pair. Executes MIPS MULT (radix-2 Booth) and DIV (restoring division on
//   operand magnitudes) at one iteration per clock. The control FSM starts
//   it with a one-cycle start pulse, stalls on busy, and uses HI/LO once
//   done is seen.
//
// Ports
//   clk         in   1      system clock, rising edge
//   reset       in   1      synchronous active-high reset
//   start_mult  in   1      request signed a*b (sampled only in IDLE)
//   start_div   in   1      request signed a/b (sampled only in IDLE)
//   a           in   WIDTH  multiplicand / dividend, latched at start
//   b           in   WIDTH  multiplier / divisor, latched at start
//   busy        out  1      high in every state except IDLE
//   done        out  1      one-cycle pulse, HI/LO valid in that cycle
//   div_zero    out  1      pulse with done when the divisor was zero
//   hi_out      out  WIDTH  HI (product upper half / remainder)
//   lo_out      out  WIDTH  LO (product lower half / quotient)
// ---------------------------------------------------------------------------
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's complement negate when sel is set.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic sel);
        return sel ? -x : x;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc_hi: Booth partial product A (sign-extended) or division remainder.
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    // acc_lo: Booth multiplier Q, or dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             qm1_q, qm1_d;
    // m: multiplicand (signed) or divisor magnitude (unsigned).
    logic [WIDTH-1:0] m_q, m_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH+1:0] div_diff_s;
    logic             q_bit_s;

    // Next-state, datapath iteration and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        qm1_d       = qm1_q;
        m_d         = m_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dz_d        = 1'b0;
        booth_sum_s = '0;
        div_shift_s = '0;
        div_diff_s  = '0;
        q_bit_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_mult) begin
                    m_d      = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    qm1_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_MULT;
                end else if (start_div) begin
                    if (b != '0) begin
                        m_d      = neg_if(b, b[WIDTH-1]);
                        acc_lo_d = neg_if(a, a[WIDTH-1]);
                        acc_hi_d = '0;
                        qneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        rneg_d   = a[WIDTH-1];
                        cnt_d    = '0;
                        state_d  = S_DIV;
                    end else begin
                        // Zero divisor: finish immediately, HI/LO untouched.
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_MULT: begin
                case ({acc_lo_q[0], qm1_q})
                    2'b01:   booth_sum_s = acc_hi_q + {m_q[WIDTH-1], m_q};
                    2'b10:   booth_sum_s = acc_hi_q - {m_q[WIDTH-1], m_q};
                    default: booth_sum_s = acc_hi_q;
                endcase
                // The add is done at WIDTH+1 bits so A - (-2^(W-1)) cannot
                // overflow; after the arithmetic shift A fits in WIDTH bits again.
                acc_hi_d = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
                acc_lo_d = {booth_sum_s[0], acc_lo_q[WIDTH-1:1]};
                qm1_d    = acc_lo_q[0];
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    hi_d    = booth_sum_s[WIDTH:1];
                    lo_d    = {booth_sum_s[0], acc_lo_q[WIDTH-1:1]};
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MULT;
                end
            end

            S_DIV: begin
                div_shift_s = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
                div_diff_s  = {1'b0, div_shift_s} - {2'b00, m_q};
                // No borrow means the trial subtraction fits: keep it.
                q_bit_s     = ~div_diff_s[WIDTH+1];
                acc_hi_d    = q_bit_s ? div_diff_s[WIDTH:0] : div_shift_s;
                acc_lo_d    = {acc_lo_q[WIDTH-2:0], q_bit_s};
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    lo_d    = neg_if({acc_lo_q[WIDTH-2:0], q_bit_s}, qneg_q);
                    hi_d    = neg_if(acc_hi_d[WIDTH-1:0], rneg_q);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule
